// File: rtl/branch_resolve_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_stage_pkg
// Brief   : Shared encodings for the execute-stage control-flow resolver.
// Revision: 1.0 - initial release
// ============================================================================
package branch_resolve_stage_pkg;

  localparam logic [2:0] c_f3_beq  = 3'b000;
  localparam logic [2:0] c_f3_bne  = 3'b001;
  localparam logic [2:0] c_f3_blt  = 3'b100;
  localparam logic [2:0] c_f3_bge  = 3'b101;
  localparam logic [2:0] c_f3_bltu = 3'b110;
  localparam logic [2:0] c_f3_bgeu = 3'b111;

  localparam logic [3:0] c_cause_misaligned = 4'd0;
  localparam logic [3:0] c_cause_illegal    = 4'd2;

  localparam logic [31:0] c_default_reset_vector = 32'h0000_0000;
  localparam logic [31:0] c_default_trap_vector  = 32'h0000_0100;

  typedef enum logic [1:0] {
    CF_NONE   = 2'd0,
    CF_BRANCH = 2'd1,
    CF_JAL    = 2'd2,
    CF_JALR   = 2'd3
  } cf_kind_e;

  // Conflicting decode flags resolve as jalr > jal > branch.
  function automatic cf_kind_e decode_kind(input logic br, input logic jal, input logic jalr);
    if (jalr)     return CF_JALR;
    else if (jal) return CF_JAL;
    else if (br)  return CF_BRANCH;
    else          return CF_NONE;
  endfunction

  function automatic logic is_illegal_f3(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_stage_cmp.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_stage_cmp
// Brief   : Branch condition comparator (funct3 selects the relation).
// Revision: 1.0 - initial release
// ============================================================================
module branch_resolve_stage_cmp
  import branch_resolve_stage_pkg::*;
(
  input  logic [2:0]  operation,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  output logic        taken
);

  logic w_eq, w_lt, w_ltu;

  assign w_eq  = (operand1 == operand2);
  assign w_lt  = ($signed(operand1) < $signed(operand2));
  assign w_ltu = (operand1 < operand2);

  always_comb begin
    taken = 1'b0;
    case (operation)
      c_f3_beq:  taken = w_eq;
      c_f3_bne:  taken = ~w_eq;
      c_f3_blt:  taken = w_lt;
      c_f3_bge:  taken = ~w_lt;
      c_f3_bltu: taken = w_ltu;
      c_f3_bgeu: taken = ~w_ltu;
      default:   taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_stage.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_stage
// Brief   : Resolves branches/jumps, owns the PC, one registered output stage.
// Revision: 1.0 - initial release
// ============================================================================
module branch_resolve_stage
  import branch_resolve_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = c_default_reset_vector,
  parameter logic [31:0] TRAP_VECTOR  = c_default_trap_vector
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_value,
  input  logic [31:0] rs2_value,
  input  logic [31:0] immediate,
  output logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_redirect,
  output logic [31:0] out_next_pc,
  output logic [31:0] out_link,
  output logic        out_trap,
  output logic [3:0]  out_cause
);

  logic [31:0] r_pc, r_next_pc, r_link;
  logic        r_valid, r_redirect, r_trap;
  logic [3:0]  r_cause;

  cf_kind_e    w_kind;
  logic        w_accept, w_taken, w_illegal, w_cf_taken, w_misaligned, w_trap;
  logic [31:0] w_pc_plus4, w_target, w_next_pc;
  logic [3:0]  w_cause;

  branch_resolve_stage_cmp u_cmp (
    .operation (funct3),
    .operand1  (rs1_value),
    .operand2  (rs2_value),
    .taken     (w_taken)
  );

  assign in_ready   = ~r_valid | out_ready;
  assign w_accept   = in_valid & in_ready;
  assign w_kind     = decode_kind(is_branch, is_jal, is_jalr);
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_illegal  = (w_kind == CF_BRANCH) && is_illegal_f3(funct3);

  always_comb begin
    w_target   = r_pc + immediate;
    w_cf_taken = 1'b0;
    case (w_kind)
      CF_BRANCH: w_cf_taken = w_taken & ~w_illegal;
      CF_JAL:    w_cf_taken = 1'b1;
      CF_JALR: begin
        w_cf_taken = 1'b1;
        w_target   = (rs1_value + immediate) & 32'hFFFF_FFFE;
      end
      default:   w_cf_taken = 1'b0;
    endcase
  end

  // Only a target actually taken can fault; a not-taken branch never traps.
  assign w_misaligned = w_cf_taken & (w_target[1:0] != 2'b00);
  assign w_trap       = w_illegal | w_misaligned;
  assign w_cause      = w_illegal ? c_cause_illegal : c_cause_misaligned;
  assign w_next_pc    = w_trap     ? TRAP_VECTOR :
                        w_cf_taken ? w_target    : w_pc_plus4;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= RESET_VECTOR;
      r_valid    <= 1'b0;
      r_redirect <= 1'b0;
      r_trap     <= 1'b0;
      r_next_pc  <= 32'd0;
      r_link     <= 32'd0;
      r_cause    <= 4'd0;
    end else begin
      if (w_accept) begin
        r_valid    <= 1'b1;
        r_pc       <= w_next_pc;
        r_next_pc  <= w_next_pc;
        r_link     <= w_pc_plus4;
        r_redirect <= w_trap | w_cf_taken;
        r_trap     <= w_trap;
        r_cause    <= w_cause;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign pc           = r_pc;
  assign out_valid    = r_valid;
  assign out_redirect = r_redirect;
  assign out_next_pc  = r_next_pc;
  assign out_link     = r_link;
  assign out_trap     = r_trap;
  assign out_cause    = r_cause;

endmodule
`default_nettype wire
